// File: rtl/xbar_push_arb.sv
// xbar_push_arb: push crossbar; each output round-robin arbitrates among the inputs targeting it, one register stage per output.
// Define XBAR_PUSH_DROP_CNT_EN to add drop_count_o, a saturating count of out-of-range transfers.
module xbar_push_arb #(
   parameter int ElemWidth = 4,
   parameter int NumElem   = 6,
   localparam int SelW     = $clog2(NumElem)
) (
   input  logic                              clk_i,
   input  logic                              arst_ni,
   input  logic [NumElem-1:0][ElemWidth-1:0] in_data_i,
   input  logic [NumElem-1:0][SelW-1:0]      in_dest_i,
   input  logic [NumElem-1:0]                in_valid_i,
   output logic [NumElem-1:0]                in_ready_o,
   output logic [NumElem-1:0][ElemWidth-1:0] out_data_o,
   output logic [NumElem-1:0][SelW-1:0]      out_src_o,
   output logic [NumElem-1:0]                out_valid_o,
   input  logic [NumElem-1:0]                out_ready_i
`ifdef XBAR_PUSH_DROP_CNT_EN
   ,
   output logic [15:0]                       drop_count_o
`endif
);
   logic [NumElem-1:0][SelW-1:0]      ptr_q, ptr_d, out_src_q, out_src_d;
   logic [NumElem-1:0][ElemWidth-1:0] out_data_q, out_data_d;
   logic [NumElem-1:0]                out_valid_q, out_valid_d, can_acc, bad;
   logic [NumElem-1:0][NumElem-1:0]   gnt;

   // Second pass overwrites the first: the lowest requester at or above ptr wins, else the lowest wrapped one.
   always_comb begin
      gnt = '0;
      for (int j = 0; j < NumElem; j++) begin
         can_acc[j] = !out_valid_q[j] || out_ready_i[j];
         for (int i = NumElem - 1; i >= 0; i--)
            if (in_valid_i[i] && in_dest_i[i] == SelW'(j) && SelW'(i) < ptr_q[j]) gnt[j] = NumElem'(1) << i;
         for (int i = NumElem - 1; i >= 0; i--)
            if (in_valid_i[i] && in_dest_i[i] == SelW'(j) && SelW'(i) >= ptr_q[j]) gnt[j] = NumElem'(1) << i;
      end
      for (int i = 0; i < NumElem; i++) begin
         bad[i] = int'(in_dest_i[i]) >= NumElem;
         in_ready_o[i] = bad[i];
         for (int j = 0; j < NumElem; j++) in_ready_o[i] = in_ready_o[i] || (gnt[j][i] && can_acc[j]);
         in_ready_o[i] = in_ready_o[i] && arst_ni;
      end
   end

   always_comb begin
      out_valid_d = out_valid_q & ~out_ready_i;
      out_data_d  = out_data_q;
      out_src_d   = out_src_q;
      ptr_d       = ptr_q;
      for (int j = 0; j < NumElem; j++)
         for (int i = 0; i < NumElem; i++)
            if (gnt[j][i] && can_acc[j]) begin
               out_valid_d[j] = 1'b1;
               out_data_d[j]  = in_data_i[i];
               out_src_d[j]   = SelW'(i);
               ptr_d[j]       = (i == NumElem - 1) ? '0 : SelW'(i + 1);
            end
   end

   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         ptr_q       <= '0;
         out_valid_q <= '0;
         out_data_q  <= '0;
         out_src_q   <= '0;
      end else begin
         ptr_q       <= ptr_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_src_q   <= out_src_d;
      end
   end

   assign out_valid_o = out_valid_q;
   assign out_data_o  = out_data_q;
   assign out_src_o   = out_src_q;

`ifdef XBAR_PUSH_DROP_CNT_EN
   logic [15:0] drop_count_q, drop_count_d;
   logic [16:0] drop_sum;

   always_comb begin
      drop_sum = {1'b0, drop_count_q};
      for (int i = 0; i < NumElem; i++) drop_sum = drop_sum + 17'(in_valid_i[i] && bad[i]);
      drop_count_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
   end

   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) drop_count_q <= '0;
      else drop_count_q <= drop_count_d;
   end

   assign drop_count_o = drop_count_q;
`endif
endmodule
